// File: rtl/csr_file_if.sv
// Shared CSR types and the write-back / redirect interface between
// the pipeline and the machine-mode CSR file.
package csr_pkg;
   typedef enum logic [3:0] {
      EXC_IMISALIGN = 4'd0,
      EXC_IFAULT    = 4'd1,
      EXC_ILLEGAL   = 4'd2,
      EXC_BREAK     = 4'd3,
      EXC_LMISALIGN = 4'd4,
      EXC_LFAULT    = 4'd5,
      EXC_SMISALIGN = 4'd6,
      EXC_SFAULT    = 4'd7,
      EXC_ECALL_U   = 4'd8,
      EXC_ECALL_S   = 4'd9,
      EXC_ECALL_M   = 4'd11
   } exc_e;

   typedef enum logic [1:0] {
      INT_SW = 2'd0,
      INT_TR = 2'd1,
      INT_EX = 2'd2
   } irq_e;

   typedef struct packed {
      logic        valid;
      logic        w_valid;
      logic [11:0] wa;
      logic [63:0] wd;
      logic        is_mret;
      logic        is_exception;
      exc_e        exception;
      logic        is_interrupt;
      irq_e        m_interrupt;
      logic [63:0] pc;
   } csr_input_t;
endpackage

interface csr_file_if;
   import csr_pkg::*;
   csr_input_t  csr_input;
   logic [11:0] ra;
   logic [63:0] rd;
   logic        redirect_valid;
   logic [63:0] redirect_pc;

   modport master (
      output csr_input, ra,
      input  rd, redirect_valid, redirect_pc
   );
   modport slave (
      input  csr_input, ra,
      output rd, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: CSR writes, trap entry, mret and the
// one-cycle refetch redirect that follows every trap or mret.
module csr_file
   import csr_pkg::*;
#(
   parameter logic [63:0] MTVEC_RST = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   csr_file_if.slave   bus
);
   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;

   logic [63:0] mstatus_q, mstatus_d;
   logic [63:0] mie_q, mie_d;
   logic [63:0] mtvec_q, mtvec_d;
   logic [63:0] mscratch_q, mscratch_d;
   logic [63:0] mepc_q, mepc_d;
   logic [63:0] mcause_q, mcause_d;
   logic [63:0] mtval_q, mtval_d;
   logic [63:0] mip_q, mip_d;
   logic [63:0] mcycle_q, mcycle_d;
   logic        rv_q, rv_d;
   logic [63:0] rpc_q, rpc_d;

   csr_input_t ev;
   logic [3:0] irq_code;
   logic       irq_take;
   logic       trap;

   assign ev = bus.csr_input;

   always_comb begin
      irq_code = 4'd11;
      unique case (ev.m_interrupt)
         INT_SW:  irq_code = 4'd3;
         INT_TR:  irq_code = 4'd7;
         default: irq_code = 4'd11;
      endcase
   end

   assign irq_take = mstatus_q[3] & mie_q[irq_code];

   always_comb begin
      mstatus_d  = mstatus_q;
      mie_d      = mie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      mip_d      = mip_q;
      mcycle_d   = mcycle_q + 64'd1;
      rv_d       = 1'b0;
      rpc_d      = '0;
      trap       = 1'b0;
      if (ev.valid) begin
         if (ev.w_valid) begin
            unique case (ev.wa)
               A_MSTATUS:  mstatus_d  = ev.wd;
               A_MIE:      mie_d      = ev.wd;
               A_MTVEC:    mtvec_d    = ev.wd;
               A_MSCRATCH: mscratch_d = ev.wd;
               A_MEPC:     mepc_d     = ev.wd;
               A_MCAUSE:   mcause_d   = ev.wd;
               A_MTVAL:    mtval_d    = ev.wd;
               A_MIP:      mip_d      = ev.wd;
               A_MCYCLE:   mcycle_d   = ev.wd;
               default:    ;
            endcase
         end else if (ev.is_mret) begin
            mstatus_d[3]     = mstatus_q[7];
            mstatus_d[7]     = 1'b1;
            mstatus_d[12:11] = 2'b11;
            rv_d             = 1'b1;
            rpc_d            = mepc_q;
         end else if (ev.is_exception) begin
            trap     = 1'b1;
            mcause_d = {1'b0, 59'd0, ev.exception};
         end else if (ev.is_interrupt && irq_take) begin
            trap     = 1'b1;
            mcause_d = {1'b1, 59'd0, irq_code};
         end
      end
      // Shared trap entry for exceptions and taken interrupts
      if (trap) begin
         mepc_d           = ev.pc;
         mstatus_d[7]     = mstatus_q[3];
         mstatus_d[3]     = 1'b0;
         mstatus_d[12:11] = 2'b11;
         rv_d             = 1'b1;
         rpc_d            = {mtvec_q[63:2], 2'b00};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mstatus_q  <= '0;
         mie_q      <= '0;
         mtvec_q    <= MTVEC_RST;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
         mip_q      <= '0;
         mcycle_q   <= '0;
         rv_q       <= 1'b0;
         rpc_q      <= '0;
      end else begin
         mstatus_q  <= mstatus_d;
         mie_q      <= mie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
         mip_q      <= mip_d;
         mcycle_q   <= mcycle_d;
         rv_q       <= rv_d;
         rpc_q      <= rpc_d;
      end
   end

   always_comb begin
      bus.rd = '0;
      unique case (bus.ra)
         A_MSTATUS:  bus.rd = mstatus_q;
         A_MIE:      bus.rd = mie_q;
         A_MTVEC:    bus.rd = mtvec_q;
         A_MSCRATCH: bus.rd = mscratch_q;
         A_MEPC:     bus.rd = mepc_q;
         A_MCAUSE:   bus.rd = mcause_q;
         A_MTVAL:    bus.rd = mtval_q;
         A_MIP:      bus.rd = mip_q;
         A_MCYCLE:   bus.rd = mcycle_q;
         default:    bus.rd = '0;
      endcase
   end

   assign bus.redirect_valid = rv_q;
   assign bus.redirect_pc    = rpc_q;
endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: stimulus pushes expected reads and
// redirect targets into queues, a negedge monitor pops and compares.
module tb_csr_file;
   import csr_pkg::*;

   localparam logic [63:0] RST_TV = 64'h400;

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rd_req = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   rd_id = 0;

   logic [63:0] rd_q[$];
   logic [11:0] ra_q[$];
   logic [63:0] rdr_q[$];

   csr_file_if bus ();

   csr_file #(.MTVEC_RST(RST_TV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rd_req) begin
         logic [63:0] e;
         logic [11:0] a;
         e = rd_q.pop_front();
         a = ra_q.pop_front();
         checks++;
         if (bus.rd !== e) begin
            errors++;
            $display("FAIL rd ra=%h got %h want %h", a, bus.rd, e);
         end
      end
      if (bus.redirect_valid) begin
         checks++;
         if (rdr_q.size() == 0) begin
            errors++;
            $display("FAIL redirect unexpected pc=%h", bus.redirect_pc);
         end else begin
            logic [63:0] e;
            e = rdr_q.pop_front();
            if (bus.redirect_pc !== e) begin
               errors++;
               $display("FAIL redirect_pc got %h want %h",
                        bus.redirect_pc, e);
            end
         end
      end
   end

   task automatic chk(input string n, input logic [63:0] g,
                      input logic [63:0] e);
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL %s got %h want %h", n, g, e);
      end
   endtask

   task automatic step(input csr_input_t c, input bit rc,
                       input logic [11:0] a, input logic [63:0] e);
      @(posedge clk);
      #1;
      bus.csr_input = c;
      bus.ra = a;
      rd_req = rc;
      if (rc) begin
         rd_q.push_back(e);
         ra_q.push_back(a);
      end
   endtask

   function automatic csr_input_t f_idle();
      f_idle = '0;
   endfunction

   function automatic csr_input_t f_wr(input logic [11:0] a,
                                       input logic [63:0] d);
      f_wr = '0;
      f_wr.valid = 1'b1;
      f_wr.w_valid = 1'b1;
      f_wr.wa = a;
      f_wr.wd = d;
   endfunction

   function automatic csr_input_t f_exc(input exc_e x,
                                        input logic [63:0] pc);
      f_exc = '0;
      f_exc.valid = 1'b1;
      f_exc.is_exception = 1'b1;
      f_exc.exception = x;
      f_exc.pc = pc;
   endfunction

   function automatic csr_input_t f_irq(input irq_e q,
                                        input logic [63:0] pc);
      f_irq = '0;
      f_irq.valid = 1'b1;
      f_irq.is_interrupt = 1'b1;
      f_irq.m_interrupt = q;
      f_irq.pc = pc;
   endfunction

   function automatic csr_input_t f_mret();
      f_mret = '0;
      f_mret.valid = 1'b1;
      f_mret.is_mret = 1'b1;
   endfunction

   task automatic wr(input logic [11:0] a, input logic [63:0] d);
      step(f_wr(a, d), 1'b0, 12'h0, 64'h0);
   endtask

   task automatic rdc(input logic [11:0] a, input logic [63:0] e);
      step(f_idle(), 1'b1, a, e);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      csr_input_t c;
      bus.csr_input = '0;
      bus.ra = '0;
      // reset state
      rdc(A_MTVEC, RST_TV);
      rdc(A_MSTATUS, 64'h0);
      rdc(A_MCYCLE, 64'h0);
      release_reset();
      rdc(A_MCYCLE, 64'h1);
      rdc(A_MCYCLE, 64'h2);

      // exception entry
      wr(A_MTVEC, 64'h8000_0103);
      wr(A_MSTATUS, 64'h8);
      rdr_q.push_back(64'h8000_0100);
      step(f_exc(EXC_ILLEGAL, 64'h8000_0040), 1'b0, 12'h0, 64'h0);
      rdc(A_MEPC, 64'h8000_0040);
      rdc(A_MCAUSE, 64'h2);
      rdc(A_MSTATUS, 64'h1880);

      // taken timer interrupt
      wr(A_MSTATUS, 64'h8);
      wr(A_MIE, 64'h80);
      rdr_q.push_back(64'h8000_0100);
      step(f_irq(INT_TR, 64'h1000), 1'b0, 12'h0, 64'h0);
      rdc(A_MCAUSE, 64'h8000_0000_0000_0007);
      rdc(A_MEPC, 64'h1000);
      rdc(A_MSTATUS, 64'h1880);

      // masked interrupts: mie bit clear, then MIE clear
      wr(A_MSTATUS, 64'h8);
      wr(A_MIE, 64'h0);
      step(f_irq(INT_TR, 64'h3000), 1'b0, 12'h0, 64'h0);
      rdc(A_MEPC, 64'h1000);
      rdc(A_MCAUSE, 64'h8000_0000_0000_0007);
      rdc(A_MSTATUS, 64'h8);
      wr(A_MSTATUS, 64'h0);
      wr(A_MIE, 64'h800);
      step(f_irq(INT_EX, 64'h3004), 1'b0, 12'h0, 64'h0);
      rdc(A_MEPC, 64'h1000);

      // taken external interrupt
      wr(A_MSTATUS, 64'h8);
      rdr_q.push_back(64'h8000_0100);
      step(f_irq(INT_EX, 64'h1234), 1'b0, 12'h0, 64'h0);
      rdc(A_MCAUSE, 64'h8000_0000_0000_000B);
      rdc(A_MEPC, 64'h1234);

      // mret
      wr(A_MEPC, 64'h2000);
      wr(A_MSTATUS, 64'h80);
      rdr_q.push_back(64'h2000);
      step(f_mret(), 1'b0, 12'h0, 64'h0);
      rdc(A_MSTATUS, 64'h1888);
      rdc(A_MEPC, 64'h2000);

      // back-to-back trap then mret
      rdr_q.push_back(64'h8000_0100);
      step(f_exc(EXC_ECALL_M, 64'h5000), 1'b0, 12'h0, 64'h0);
      rdr_q.push_back(64'h5000);
      step(f_mret(), 1'b0, 12'h0, 64'h0);
      rdc(A_MSTATUS, 64'h1888);
      rdc(A_MCAUSE, 64'hB);
      rdc(A_MEPC, 64'h5000);

      // write wins over simultaneous exception
      c = f_wr(A_MSCRATCH, 64'hDEAD);
      c.is_exception = 1'b1;
      c.exception = EXC_BREAK;
      c.pc = 64'h9999;
      step(c, 1'b0, 12'h0, 64'h0);
      rdc(A_MSCRATCH, 64'hDEAD);
      rdc(A_MEPC, 64'h5000);

      // valid=0 ignores everything
      c = f_exc(EXC_LFAULT, 64'h7777);
      c.valid = 1'b0;
      step(c, 1'b0, 12'h0, 64'h0);
      c = f_wr(A_MSCRATCH, 64'h1);
      c.valid = 1'b0;
      step(c, 1'b0, 12'h0, 64'h0);
      rdc(A_MEPC, 64'h5000);
      rdc(A_MSCRATCH, 64'hDEAD);

      // no write-to-read bypass
      step(f_wr(A_MSCRATCH, 64'h55), 1'b1, A_MSCRATCH, 64'hDEAD);
      rdc(A_MSCRATCH, 64'h55);

      // mcycle wrap, unmapped write, mip
      wr(A_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
      rdc(A_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
      rdc(A_MCYCLE, 64'h0);
      wr(12'h7C0, 64'h1234);
      rdc(12'h7C0, 64'h0);
      rdc(A_MSCRATCH, 64'h55);
      rdc(A_MTVEC, 64'h8000_0103);
      wr(A_MIP, 64'h888);
      rdc(A_MIP, 64'h888);

      // reset while a redirect pulse is live
      step(f_exc(EXC_SFAULT, 64'h6000), 1'b0, 12'h0, 64'h0);
      @(posedge clk);
      #1;
      chk("rv_before_reset", {63'd0, bus.redirect_valid}, 64'h1);
      bus.csr_input = '0;
      reset = 1'b1;
      #1;
      chk("rv_after_reset", {63'd0, bus.redirect_valid}, 64'h0);
      chk("rpc_after_reset", bus.redirect_pc, 64'h0);
      rdc(A_MTVEC, RST_TV);
      rdc(A_MCYCLE, 64'h0);
      rdc(A_MEPC, 64'h0);
      // event held across reset is discarded
      step(f_exc(EXC_ILLEGAL, 64'hAAAA), 1'b0, 12'h0, 64'h0);
      step(f_idle(), 1'b0, 12'h0, 64'h0);
      release_reset();
      rdc(A_MCYCLE, 64'h1);
      rdc(A_MEPC, 64'h0);

      step(f_idle(), 1'b0, 12'h0, 64'h0);
      step(f_idle(), 1'b0, 12'h0, 64'h0);
      chk("redirect_queue_empty", 64'(rdr_q.size()), 64'h0);
      chk("read_queue_empty", 64'(rd_q.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 Parameter MTVEC_RST, default 64'h0, reset value of mtvec.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 csr_input  in  csr_input_t  write-back request: valid, w_valid, wa[11:0], wd[63:0], is_mret, is_exception, exception, is_interrupt, m_interrupt, pc[63:0].
REQ-005 ra  in  12  combinational read address.
REQ-006 rd  out  64  read data for ra.
REQ-007 redirect_valid  out  1  one-cycle pulse requesting pipeline flush and refetch.
REQ-008 redirect_pc  out  64  refetch target; meaningful only while redirect_valid=1.

Function
REQ-009 Registers and addresses: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00; all 64 bits.
REQ-010 rd = current register value for ra; any unmapped ra returns 64'h0; no write-to-read bypass, so a same-cycle write is visible on rd from the next cycle.
REQ-011 An event is accepted only when csr_input.valid=1; with valid=0 all other csr_input fields are ignored.
REQ-012 Event priority when several flags are set: w_valid > is_mret > is_exception > is_interrupt; only the highest is acted on.
REQ-013 CSR write (w_valid): register at wa <= wd at the next edge; an unmapped wa changes nothing; no redirect.
REQ-014 mcycle increments by 1 every cycle, wrapping 2^64-1 -> 0; a software write to mcycle overrides the increment in that cycle.
REQ-015 Exception: mepc <= pc; mcause <= {1'b0, 63-bit cause}, where the cause is the integer encoding of csr_input.exception; mstatus.MPIE(bit 7) <= MIE(bit 3); MIE <= 0; MPP(bits 12:11) <= 2'b11.
REQ-016 Interrupt: taken only if mstatus.MIE=1 and the matching mie bit is 1 (SWINT bit 3, TRINT bit 7, EXINT bit 11); otherwise fully ignored, with no state change and no redirect.
REQ-017 A taken interrupt updates mepc, mstatus and MPP as in REQ-015, and sets mcause <= {1'b1, code} with code 3/7/11 for SWINT/TRINT/EXINT.
REQ-018 mret: mstatus.MIE <= MPIE; MPIE <= 1; MPP <= 2'b11; mepc and mcause unchanged.
REQ-019 Trap redirect: redirect_valid=1 exactly one cycle after acceptance; redirect_pc = {mtvec[63:2], 2'b00}, using the mtvec value at acceptance (direct mode only).
REQ-020 mret redirect: redirect_valid=1 exactly one cycle after acceptance; redirect_pc = mepc as it stood at acceptance.
REQ-021 redirect_valid stays high for exactly one cycle per accepted trap/mret; back-to-back accepted events produce back-to-back pulses, each carrying its own target.
REQ-022 CSR writes and ignored interrupts never assert redirect_valid.

Reset
REQ-023 On reset assertion, immediately and independently of clk: mtvec = MTVEC_RST; all other registers = 0; redirect_valid = 0; redirect_pc = 0.
REQ-024 An event presented in the same cycle that reset is asserted is discarded, and any pending redirect pulse is cancelled.
REQ-025 After reset deasserts, the first rising edge already accepts events and increments mcycle (0 -> 1).

Verification
REQ-026 Write mtvec=0x8000_0103, then raise exception pc=0x8000_0040 -> next cycle redirect_valid=1, redirect_pc=0x8000_0100; mepc=0x8000_0040; mstatus.MIE=0, MPIE=old MIE, MPP=3.
REQ-027 mstatus=0x8, mie=0x80, TRINT at pc=0x1000 -> mcause=0x8000_0000_0000_0007, mepc=0x1000, one-cycle redirect; repeat with mie=0 -> no state change, no redirect.
REQ-028 mepc=0x2000, mstatus.MPIE=1, then mret -> next cycle redirect_pc=0x2000, mstatus.MIE=1, MPIE=1.
REQ-029 valid=1 with w_valid=1 and is_exception=1 together -> only the CSR write occurs; mepc unchanged; no redirect.
REQ-030 Write mcycle=0xFFFF_FFFF_FFFF_FFFF -> reads 0 one cycle later; write to unmapped 0x7C0 -> all registers unchanged, rd(0x7C0)=0.
REQ-031 Assert reset mid-redirect (exception accepted in the previous cycle) -> redirect_valid drops to 0 immediately; mtvec=MTVEC_RST; mcycle=0.
